// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program counter.
package pc_pkg;

    localparam int unsigned ILEN_BYTES = 4;

    typedef enum logic [2:0] {
        PC_SEL_SEQ,
        PC_SEL_RAS,
        PC_SEL_HOLD,
        PC_SEL_REDIRECT,
        PC_SEL_ERET,
        PC_SEL_TRAP,
        PC_SEL_RESET
    } pc_sel_t;

    // True for the sources that actually advance fetch; only these may touch the RAS.
    function automatic logic sel_advances(input pc_sel_t sel);
        return (sel == PC_SEL_SEQ) || (sel == PC_SEL_RAS);
    endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack with saturating count and replace-top on push+pop.
module return_address_stack
    import pc_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RES,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [XLEN-1:0] pushData,
    output logic [XLEN-1:0] topData,
    output logic            empty,
    output logic            full
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            we;
    logic [PtrW-1:0] waddr;
    logic            do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CntW'(DEPTH));
    assign topData = mem_q[ptr_q];
    assign do_pop  = pop && !empty;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        we    = 1'b0;
        waddr = ptr_q;
        if (clear) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push && do_pop) begin
            we = 1'b1;
        end else if (push) begin
            // Pointer wraps modulo DEPTH, so a push when full overwrites the oldest entry.
            ptr_d = ptr_q + PtrW'(1);
            waddr = ptr_d;
            we    = 1'b1;
            if (!full) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (do_pop) begin
            ptr_d = ptr_q - PtrW'(1);
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[waddr] <= pushData;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: prioritised next-PC selection, trap EPC and RAS prediction.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned    XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned    RAS_DEPTH    = 4
) (
    input  logic            CLK,
    input  logic            RES,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirectTarget,
    input  logic            trap,
    input  logic [XLEN-1:0] trapPc,
    input  logic            eret,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] pcPlus4,
    output logic [XLEN-1:0] epc,
    output logic            rasEmpty,
    output logic            misaligned
);

    pc_sel_t         sel;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_clear;
    logic            unused_ras_full;

    assign pcPlus4    = pc_q + XLEN'(ILEN_BYTES);
    assign PC         = pc_q;
    assign epc        = epc_q;
    assign misaligned = mis_q;

    always_comb begin
        sel = PC_SEL_SEQ;
        if (RES) begin
            sel = PC_SEL_RESET;
        end else if (trap) begin
            sel = PC_SEL_TRAP;
        end else if (eret) begin
            sel = PC_SEL_ERET;
        end else if (redirect) begin
            sel = PC_SEL_REDIRECT;
        end else if (stall) begin
            sel = PC_SEL_HOLD;
        end else if (ret && !rasEmpty) begin
            sel = PC_SEL_RAS;
        end
    end

    always_comb begin
        pc_d  = pcPlus4;
        epc_d = epc_q;
        mis_d = 1'b0;
        case (sel)
            PC_SEL_RESET: begin
                pc_d  = RESET_VECTOR;
                epc_d = '0;
            end
            PC_SEL_TRAP: begin
                pc_d  = TRAP_VECTOR;
                epc_d = trapPc;
            end
            PC_SEL_ERET:     pc_d = epc_q;
            PC_SEL_REDIRECT: begin
                pc_d  = {redirectTarget[XLEN-1:2], 2'b00};
                mis_d = |redirectTarget[1:0];
            end
            PC_SEL_HOLD:     pc_d = pc_q;
            PC_SEL_RAS:      pc_d = ras_top;
            default:         pc_d = pcPlus4;
        endcase
    end

    // With call+ret together the RAS replaces its top, so the popped value must be read first.
    assign ras_push  = call && sel_advances(sel);
    assign ras_pop   = (sel == PC_SEL_RAS);
    assign ras_clear = (sel == PC_SEL_TRAP);

    return_address_stack #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK      (CLK),
        .RES      (RES),
        .push     (ras_push),
        .pop      (ras_pop),
        .clear    (ras_clear),
        .pushData (pcPlus4),
        .topData  (ras_top),
        .empty    (rasEmpty),
        .full     (unused_ras_full)
    );

    always_ff @(posedge CLK) begin
        if (RES) begin
            pc_q  <= RESET_VECTOR;
            epc_q <= '0;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            mis_q <= mis_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit: stimulus queues expected state, monitor compares.
module tb_pc_unit;

    logic        CLK;
    logic        RES;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic        trap;
    logic [31:0] trapPc;
    logic        eret;
    logic        call;
    logic        ret;
    logic [31:0] PC;
    logic [31:0] pcPlus4;
    logic [31:0] epc;
    logic        rasEmpty;
    logic        misaligned;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        re;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_1000),
        .TRAP_VECTOR  (32'h0000_0100),
        .RAS_DEPTH    (4)
    ) dut (
        .CLK            (CLK),
        .RES            (RES),
        .stall          (stall),
        .redirect       (redirect),
        .redirectTarget (redirectTarget),
        .trap           (trap),
        .trapPc         (trapPc),
        .eret           (eret),
        .call           (call),
        .ret            (ret),
        .PC             (PC),
        .pcPlus4        (pcPlus4),
        .epc            (epc),
        .rasEmpty       (rasEmpty),
        .misaligned     (misaligned)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, expv);
        end
    endtask

    // Monitor: one queued expectation per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk({e.name, " PC"}, PC, e.pc);
                chk({e.name, " pcPlus4"}, pcPlus4, e.pc + 32'd4);
                chk({e.name, " epc"}, epc, e.epc);
                chk({e.name, " rasEmpty"}, {31'd0, rasEmpty}, {31'd0, e.re});
                chk({e.name, " misaligned"}, {31'd0, misaligned}, {31'd0, e.mis});
            end
        end
    end

    task automatic clear_inputs();
        RES            = 1'b0;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirectTarget = 32'd0;
        trap           = 1'b0;
        trapPc         = 32'd0;
        eret           = 1'b0;
        call           = 1'b0;
        ret            = 1'b0;
    endtask

    task automatic cyc(input string nm, input logic [31:0] p, input logic [31:0] ep,
                       input logic re, input logic mis);
        exp_t e;
        e.name = nm;
        e.pc   = p;
        e.epc  = ep;
        e.re   = re;
        e.mis  = mis;
        sb_q.push_back(e);
        @(posedge CLK);
        #2;
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();

        RES = 1'b1;                 cyc("reset",   32'h1000, 32'h0, 1'b1, 1'b0);
                                    cyc("seq1",    32'h1004, 32'h0, 1'b1, 1'b0);
                                    cyc("seq2",    32'h1008, 32'h0, 1'b1, 1'b0);
                                    cyc("seq3",    32'h100C, 32'h0, 1'b1, 1'b0);

        redirect = 1'b1; redirectTarget = 32'h20;
                                    cyc("redir20", 32'h20,   32'h0, 1'b1, 1'b0);
        stall = 1'b1; redirect = 1'b1; redirectTarget = 32'h203;
                                    cyc("redir_mis", 32'h200, 32'h0, 1'b1, 1'b1);
                                    cyc("after_mis", 32'h204, 32'h0, 1'b1, 1'b0);
        stall = 1'b1; call = 1'b1; ret = 1'b1;
                                    cyc("stall_call", 32'h204, 32'h0, 1'b1, 1'b0);

        redirect = 1'b1; redirectTarget = 32'h0;
                                    cyc("redir0",  32'h0,    32'h0, 1'b1, 1'b0);
        call = 1'b1;                cyc("call1",   32'h4,    32'h0, 1'b0, 1'b0);
        call = 1'b1;                cyc("call2",   32'h8,    32'h0, 1'b0, 1'b0);
        call = 1'b1;                cyc("call3",   32'hC,    32'h0, 1'b0, 1'b0);
        call = 1'b1;                cyc("call4",   32'h10,   32'h0, 1'b0, 1'b0);
        call = 1'b1;                cyc("call5",   32'h14,   32'h0, 1'b0, 1'b0);
        ret = 1'b1;                 cyc("ret1",    32'h14,   32'h0, 1'b0, 1'b0);
        ret = 1'b1;                 cyc("ret2",    32'h10,   32'h0, 1'b0, 1'b0);
        ret = 1'b1;                 cyc("ret3",    32'hC,    32'h0, 1'b0, 1'b0);
        ret = 1'b1;                 cyc("ret4",    32'h8,    32'h0, 1'b1, 1'b0);
        ret = 1'b1;                 cyc("ret5_empty", 32'hC, 32'h0, 1'b1, 1'b0);

        redirect = 1'b1; redirectTarget = 32'h3C;
                                    cyc("redir3c", 32'h3C,   32'h0, 1'b1, 1'b0);
        call = 1'b1;                cyc("call40",  32'h40,   32'h0, 1'b0, 1'b0);
        trap = 1'b1; trapPc = 32'h3C; eret = 1'b1; redirect = 1'b1; redirectTarget = 32'h503;
        ret = 1'b1;                 cyc("trap",    32'h100,  32'h3C, 1'b1, 1'b0);
                                    cyc("trap_seq", 32'h104, 32'h3C, 1'b1, 1'b0);
        eret = 1'b1;                cyc("eret",    32'h3C,   32'h3C, 1'b1, 1'b0);

        redirect = 1'b1; redirectTarget = 32'h7C;
                                    cyc("redir7c", 32'h7C,   32'h3C, 1'b1, 1'b0);
        call = 1'b1;                cyc("call80",  32'h80,   32'h3C, 1'b0, 1'b0);
        redirect = 1'b1; redirectTarget = 32'h50;
                                    cyc("redir50_keep_ras", 32'h50, 32'h3C, 1'b0, 1'b0);
        call = 1'b1; ret = 1'b1;    cyc("call_ret", 32'h80,  32'h3C, 1'b0, 1'b0);
        ret = 1'b1;                 cyc("ret_new_top", 32'h54, 32'h3C, 1'b1, 1'b0);
        ret = 1'b1;                 cyc("ret_empty2", 32'h58, 32'h3C, 1'b1, 1'b0);
        call = 1'b1;                cyc("call5c",  32'h5C,   32'h3C, 1'b0, 1'b0);

        RES = 1'b1; stall = 1'b1; trap = 1'b1; trapPc = 32'h999;
                                    cyc("res_over_trap", 32'h1000, 32'h0, 1'b1, 1'b0);

        redirect = 1'b1; redirectTarget = 32'hFFFF_FFFC;
                                    cyc("redir_top", 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0);
                                    cyc("wrap",    32'h0,    32'h0, 1'b1, 1'b0);

        @(posedge CLK);
        #2;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised fetch-stage program counter for the RISC-V core. It replaces the bare PC register with a prioritised next-PC selector covering reset vector, trap entry and return, resolved branch/jump redirect, stall, and a small return-address stack (RAS) for call/return prediction. It sits at the head of the fetch stage. It drives the instruction-memory address and receives redirect and trap events from the execute stage and CSR logic.

## Interface
- XLEN, 32, address/data width in bits (≥ 8).
- RESET_VECTOR, 0, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap entry.
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥ 2).
- CLK  input  1  clock; all state updates on rising edge.
- RES  input  1  one clock; reset is synchronous and active-high.
- stall  input  1  hold PC (fetch back-pressure).
- redirect  input  1  resolved branch/jump taken.
- redirectTarget  input  XLEN  target for redirect.
- trap  input  1  exception/interrupt entry.
- trapPc  input  XLEN  PC of the trapping instruction, saved to epc.
- eret  input  1  return from trap.
- call  input  1  fetched instruction is a call (push PC+4).
- ret  input  1  fetched instruction is a return (predict from RAS).
- PC  output  XLEN  current fetch address.
- pcPlus4  output  XLEN  PC + 4, combinational, wraps modulo 2^XLEN.
- epc  output  XLEN  saved exception PC.
- rasEmpty  output  1  RAS holds no valid entry.
- misaligned  output  1  registered; last redirect target had bits [1:0] ≠ 0.

## Operation
- The next-PC source is chosen each cycle in strict priority:
  1. RES: PC = RESET_VECTOR.
  2. trap: PC = TRAP_VECTOR, epc = trapPc, RAS cleared.
  3. eret: PC = epc.
  4. redirect: PC = redirectTarget with bits [1:0] forced to 0.
  5. stall: PC held.
  6. ret with RAS non-empty: PC = top of RAS, which is popped.
  7. Otherwise PC = pcPlus4.
- A ret with the RAS empty falls through to PC+4. The RAS count stays 0 and no underflow occurs.
- call pushes pcPlus4 only when source 6 or 7 is selected. Under trap, eret, redirect or stall, call and ret are ignored and the RAS is unchanged.
- call and ret in the same cycle: the PC takes the popped top, then pcPlus4 is written into the same slot. The count is unchanged (replace top).
- RAS overflow: a push when full overwrites the oldest entry (circular pointer wrap). The count saturates at RAS_DEPTH.
- Redirect does not flush the RAS. Only trap and RES clear it.
- misaligned = redirect selected AND redirectTarget[1:0] ≠ 0. It is updated every cycle and is 0 when redirect is not selected.

## Timing
- All inputs are sampled at the rising edge, and their effect on PC is visible in the following cycle (one-cycle latency).
- pcPlus4 and rasEmpty are combinational from registered state.
- Reset values: PC = RESET_VECTOR, epc = 0, RAS count = 0 (rasEmpty = 1), misaligned = 0.
- RES asserted mid-operation overrides every other input in that cycle, including trap: epc is set to 0, not trapPc.
- PC at all-ones minus 3 with no event wraps to 0.
- eret and trap in the same cycle: trap wins, and epc takes the new trapPc.

## Structure
- Shared package pc_pkg:
  - Enum pc_sel_t {PC_SEL_SEQ, PC_SEL_RAS, PC_SEL_HOLD, PC_SEL_REDIRECT, PC_SEL_ERET, PC_SEL_TRAP, PC_SEL_RESET}.
  - Constant ILEN_BYTES = 4.
- Sub-module return_address_stack (parameters XLEN, DEPTH; ports push, pop, clear, pushData, topData, empty, full).
  - Owns the circular pointer, count saturation and replace-top logic.
- pc_unit holds the priority encoder, PC and epc registers, and the misaligned flag.

## Test plan
- Reset then 3 free-running cycles, RESET_VECTOR = 0x1000 -> PC = 0x1000, 0x1004, 0x1008, 0x100C; rasEmpty = 1.
- PC = 0x20, redirect with target 0x203 while stall = 1 -> next PC = 0x200, misaligned = 1. Following idle cycle: PC = 0x204, misaligned = 0.
- Five calls at PC 0x0, 0x4, 0x8, 0xC, 0x10 (RAS_DEPTH = 4), then five rets:
  - Rets predict 0x14, 0x10, 0xC, 0x8.
  - Fifth ret falls through to PC+4 with rasEmpty = 1.
- trap at PC 0x40 with trapPc = 0x3C, simultaneous eret and redirect -> PC = TRAP_VECTOR, epc = 0x3C, RAS cleared. A later eret -> PC = 0x3C.
- call and ret together with top = 0x80, at PC 0x50 -> PC = 0x80; new top = 0x54; count unchanged.
- RES asserted while stall and trap are both high -> PC = RESET_VECTOR, epc = 0, rasEmpty = 1 next cycle.
